decoder_phase_sequencer: RTL and testbench
==========================================

// Module: decoder_phase_sequencer
// PURPOSE
//  Sequences the instruction decoder tree: owns the opcode register (ITABLE) and the execution-phase counter (XPT).
//  Runs the opcode-fetch (M1) cycle and latches the opcode. Steps XPT while the decoder is enabled.
//  Applies the decoder's end-of-instruction pulses (Reset_XPT / Set_CM1 / Reset_ITABLE / Ophd).
//  Sits between the memory interface and the top-level DECODER_I root.
// PARAMETERS
//  XPT_WIDTH     4      phase counter width; max phase = 2**XPT_WIDTH-1
//  ITABLE_WIDTH  8      opcode register width
//  NOP_OPCODE    8'h00  value loaded into ITABLE by reset and by Reset_ITABLE
// PORTS
//  clock            in   1   single system clock, rising edge
//  reset            in   1   synchronous, active-high
//  data_in          in   8   opcode byte from memory bus
//  mem_ready        in   1   1 = current bus access completes this cycle (0 = wait state)
//  halt_req         in   1   decoder request to enter HALT (sampled only together with reset_xpt)
//  int_req          in   1   interrupt request; releases HALT
//  reset_xpt        in   1   decoder PR_Reset_XPT pulse
//  set_cm1          in   1   decoder P2_Set_CM1 pulse
//  reset_itable     in   1   decoder P2_Reset_ITABLE pulse
//  ophd             in   1   decoder Pa_Ophd pulse (opcode done; clears prefix)
//  XPT / notXPT     out  4   phase counter and its complement
//  ITABLE / notITABLE out 8  opcode register and its complement
//  decoder_enable   out  1   enable for decoder root
//  m1               out  1   1 during opcode-fetch cycle
//  prefix           out  2   00 none, 01 CB, 10 DD/FD, 11 ED
//  prefix_iy        out  1   1 if the DD/FD prefix was FD
//  halted           out  1   1 in HALT state
//  phase_error      out  1   sticky XPT-overflow flag
// BEHAVIOUR
//  All outputs are registered. The complements are always the exact bitwise inverse (never transiently unequal).
//  Reset values: XPT=0, ITABLE=NOP_OPCODE, state=FETCH, m1=1, decoder_enable=0, prefix=00, prefix_iy=0, halted=0, phase_error=0.
//  States: FETCH, EXEC, HALT.
//  FETCH:
//   - m1=1, decoder_enable=0.
//   - XPT advances 0->1 only when mem_ready=1.
//   - At XPT=1 with mem_ready=1:
//     - data_in in {CB,DD,ED,FD}: record prefix (FD sets prefix_iy), XPT<=0, stay in FETCH for the next byte.
//     - DD/FD after DD/FD: the last prefix wins.
//     - Otherwise: ITABLE<=data_in, XPT<=2, go to EXEC.
//  EXEC:
//   - m1=0, decoder_enable=1.
//   - XPT increments by 1 each cycle when mem_ready=1 and holds when mem_ready=0.
//   - reset_xpt has priority over the increment and over mem_ready:
//     - XPT<=0.
//     - set_cm1=1: go to FETCH.
//     - halt_req=1 and set_cm1=0: go to HALT.
//     - Neither set_cm1 nor halt_req: stay in EXEC (multi-M-cycle instruction).
//   - reset_itable: ITABLE<=NOP_OPCODE in the same cycle.
//   - ophd: prefix<=00, prefix_iy<=0.
//  Latency: from the last fetch-cycle edge, ITABLE and decoder_enable are valid 1 cycle later.
//   - Reset_XPT to m1=1: 1 cycle.
//  Overflow: in EXEC with XPT=all-ones, an increment is suppressed.
//   - XPT holds, phase_error<=1 (sticky until reset).
//   - The FSM keeps waiting for reset_xpt.
//  Pulses reset_xpt/set_cm1/reset_itable/ophd are ignored outside EXEC.
//  HALT:
//   - halted=1, decoder_enable=0, XPT held at 0.
//   - int_req=1 -> FETCH on the next edge.
//  reset asserted in any state, mid-fetch or mid-wait: all registers return to reset values on that edge; it beats every other input.
// TESTING
//  1. Reset, then mem_ready=1, data_in=8'h3E -> m1 for 2 cycles; ITABLE=3E and notITABLE=C1 next cycle; XPT=2, decoder_enable=1.
//  2. EXEC, mem_ready=0 for 3 cycles at XPT=4 -> XPT stays 4.
//     Then reset_xpt+set_cm1 while mem_ready=0 -> XPT=0, state FETCH, m1=1.
//  3. Fetch DD then 21 -> prefix=10, prefix_iy=0, ITABLE=21.
//     Then ophd+reset_xpt+set_cm1 -> prefix=00.
//  4. Fetch FD, DD, ED, 46 -> final prefix=11, ITABLE=46.
//  5. EXEC counting from XPT=2 with no reset_xpt -> XPT sticks at 15, phase_error=1 from the 14th cycle.
//     Then reset -> phase_error=0.
//  6. reset_xpt+halt_req -> halted=1, XPT=0, decoder_enable=0.
//     int_req -> m1=1 next cycle; reset during wait state at XPT=1 -> all reset values.

Source files
------------

// File: rtl/decoder_phase_sequencer.sv
// Decoder phase sequencer: owns the opcode register (ITABLE) and the phase counter (XPT),
// runs the M1 opcode fetch including prefix bytes, and applies the decoder's end-of-instruction pulses.
module decoder_phase_sequencer #(
   parameter int unsigned               XPT_WIDTH    = 4,
   parameter int unsigned               ITABLE_WIDTH = 8,
   parameter logic [ITABLE_WIDTH-1:0]   NOP_OPCODE   = 8'h00
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              data_in,
   input  logic                    mem_ready,
   input  logic                    halt_req,
   input  logic                    int_req,
   input  logic                    reset_xpt,
   input  logic                    set_cm1,
   input  logic                    reset_itable,
   input  logic                    ophd,
   output logic [XPT_WIDTH-1:0]    XPT,
   output logic [XPT_WIDTH-1:0]    notXPT,
   output logic [ITABLE_WIDTH-1:0] ITABLE,
   output logic [ITABLE_WIDTH-1:0] notITABLE,
   output logic                    decoder_enable,
   output logic                    m1,
   output logic [1:0]              prefix,
   output logic                    prefix_iy,
   output logic                    halted,
   output logic                    phase_error
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] HALT  = 2'd2;

   localparam logic [XPT_WIDTH-1:0] XPT_ZERO   = '0;
   localparam logic [XPT_WIDTH-1:0] XPT_ONE    = XPT_WIDTH'(1);
   localparam logic [XPT_WIDTH-1:0] XPT_OPCODE = XPT_WIDTH'(2);
   localparam logic [XPT_WIDTH-1:0] XPT_MAX    = '1;

   localparam logic [7:0] BYTE_CB = 8'hCB;
   localparam logic [7:0] BYTE_DD = 8'hDD;
   localparam logic [7:0] BYTE_ED = 8'hED;
   localparam logic [7:0] BYTE_FD = 8'hFD;

   localparam logic [1:0] PFX_NONE = 2'b00;
   localparam logic [1:0] PFX_CB   = 2'b01;
   localparam logic [1:0] PFX_IXY  = 2'b10;
   localparam logic [1:0] PFX_ED   = 2'b11;

   logic [1:0]              state_q,   state_d;
   logic [XPT_WIDTH-1:0]    xpt_q,     xpt_d;
   logic [ITABLE_WIDTH-1:0] itable_q,  itable_d;
   logic [1:0]              prefix_q,  prefix_d;
   logic                    iy_q,      iy_d;
   logic                    perr_q,    perr_d;
   logic                    m1_q,      m1_d;
   logic                    en_q,      en_d;
   logic                    halted_q,  halted_d;

   logic                    is_prefix;
   logic [1:0]              prefix_code;

   always_comb begin
      is_prefix   = 1'b1;
      prefix_code = PFX_NONE;
      case (data_in)
         BYTE_CB: prefix_code = PFX_CB;
         BYTE_DD: prefix_code = PFX_IXY;
         BYTE_FD: prefix_code = PFX_IXY;
         BYTE_ED: prefix_code = PFX_ED;
         default: is_prefix   = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      xpt_d    = xpt_q;
      itable_d = itable_q;
      prefix_d = prefix_q;
      iy_d     = iy_q;
      perr_d   = perr_q;

      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               if (xpt_q == XPT_ZERO) begin
                  xpt_d = XPT_ONE;
               end else if (is_prefix) begin
                  // A later DD/FD simply overwrites an earlier one, so the last prefix wins.
                  prefix_d = prefix_code;
                  iy_d     = (data_in == BYTE_FD);
                  xpt_d    = XPT_ZERO;
               end else begin
                  itable_d = ITABLE_WIDTH'(data_in);
                  xpt_d    = XPT_OPCODE;
                  state_d  = EXEC;
               end
            end
         end

         EXEC: begin
            if (reset_itable) begin
               itable_d = NOP_OPCODE;
            end
            if (ophd) begin
               prefix_d = PFX_NONE;
               iy_d     = 1'b0;
            end
            if (reset_xpt) begin
               xpt_d = XPT_ZERO;
               if (set_cm1) begin
                  state_d = FETCH;
               end else if (halt_req) begin
                  state_d = HALT;
               end
            end else if (mem_ready) begin
               // At the last phase the counter saturates and the overflow is latched instead.
               if (xpt_q == XPT_MAX) begin
                  perr_d = 1'b1;
               end else begin
                  xpt_d = xpt_q + XPT_ONE;
               end
            end
         end

         HALT: begin
            xpt_d = XPT_ZERO;
            if (int_req) begin
               state_d = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
            xpt_d   = XPT_ZERO;
         end
      endcase

      m1_d     = (state_d == FETCH);
      en_d     = (state_d == EXEC);
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= FETCH;
         xpt_q    <= XPT_ZERO;
         itable_q <= NOP_OPCODE;
         prefix_q <= PFX_NONE;
         iy_q     <= 1'b0;
         perr_q   <= 1'b0;
         m1_q     <= 1'b1;
         en_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         xpt_q    <= xpt_d;
         itable_q <= itable_d;
         prefix_q <= prefix_d;
         iy_q     <= iy_d;
         perr_q   <= perr_d;
         m1_q     <= m1_d;
         en_q     <= en_d;
         halted_q <= halted_d;
      end
   end

   assign XPT            = xpt_q;
   assign notXPT         = ~xpt_q;
   assign ITABLE         = itable_q;
   assign notITABLE      = ~itable_q;
   assign decoder_enable = en_q;
   assign m1             = m1_q;
   assign prefix         = prefix_q;
   assign prefix_iy      = iy_q;
   assign halted         = halted_q;
   assign phase_error    = perr_q;

endmodule

// File: tb/tb_decoder_phase_sequencer.sv
// Scoreboard bench for decoder_phase_sequencer: a behavioural model predicts every registered output
// after each clock edge; a monitor pops the predictions and compares them with the DUT.
module tb_decoder_phase_sequencer;

   logic       clock;
   logic       reset;
   logic [7:0] data_in;
   logic       mem_ready, halt_req, int_req;
   logic       reset_xpt, set_cm1, reset_itable, ophd;
   logic [3:0] XPT, notXPT;
   logic [7:0] ITABLE, notITABLE;
   logic       decoder_enable, m1, prefix_iy, halted, phase_error;
   logic [1:0] prefix;

   decoder_phase_sequencer #(
      .XPT_WIDTH   (4),
      .ITABLE_WIDTH(8),
      .NOP_OPCODE  (8'h00)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .mem_ready     (mem_ready),
      .halt_req      (halt_req),
      .int_req       (int_req),
      .reset_xpt     (reset_xpt),
      .set_cm1       (set_cm1),
      .reset_itable  (reset_itable),
      .ophd          (ophd),
      .XPT           (XPT),
      .notXPT        (notXPT),
      .ITABLE        (ITABLE),
      .notITABLE     (notITABLE),
      .decoder_enable(decoder_enable),
      .m1            (m1),
      .prefix        (prefix),
      .prefix_iy     (prefix_iy),
      .halted        (halted),
      .phase_error   (phase_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef enum {MODE_FETCH, MODE_EXEC, MODE_HALT} mode_e;

   typedef struct {
      int unsigned xpt;
      int unsigned itable;
      int unsigned prefix;
      bit          iy;
      bit          perr;
      bit          m1;
      bit          en;
      bit          halted;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;

   mode_e       m_mode   = MODE_FETCH;
   int unsigned m_phase  = 0;
   int unsigned m_opcode = 0;
   int unsigned m_prefix = 0;
   bit          m_iy     = 0;
   bit          m_perr   = 0;

   localparam int unsigned PHASE_LAST = 15;

   task automatic check(input string name, input int unsigned actual, input int unsigned expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Next-cycle prediction from the behavioural rules, one clock edge at a time.
   task automatic model_edge(input bit rst, input bit mr, input int unsigned d, input bit rx,
                             input bit cm, input bit ri, input bit op, input bit hr, input bit ir);
      if (rst) begin
         m_mode = MODE_FETCH; m_phase = 0; m_opcode = 0;
         m_prefix = 0; m_iy = 0; m_perr = 0;
         return;
      end
      case (m_mode)
         MODE_FETCH: begin
            if (mr && m_phase == 0) m_phase = 1;
            else if (mr) begin
               if (d == 'hCB)      begin m_prefix = 1; m_iy = 0; m_phase = 0; end
               else if (d == 'hDD) begin m_prefix = 2; m_iy = 0; m_phase = 0; end
               else if (d == 'hFD) begin m_prefix = 2; m_iy = 1; m_phase = 0; end
               else if (d == 'hED) begin m_prefix = 3; m_iy = 0; m_phase = 0; end
               else begin m_opcode = d; m_phase = 2; m_mode = MODE_EXEC; end
            end
         end
         MODE_EXEC: begin
            if (ri) m_opcode = 0;
            if (op) begin m_prefix = 0; m_iy = 0; end
            if (rx) begin
               m_phase = 0;
               if (cm) m_mode = MODE_FETCH;
               else if (hr) m_mode = MODE_HALT;
            end else if (mr) begin
               if (m_phase < PHASE_LAST) m_phase = m_phase + 1;
               else m_perr = 1;
            end
         end
         default: begin
            m_phase = 0;
            if (ir) m_mode = MODE_FETCH;
         end
      endcase
   endtask

   // Called at a falling edge: drive inputs, push the prediction for the coming rising edge,
   // then return at the next falling edge with the DUT outputs settled.
   task automatic step(input bit rst, input bit mr, input int unsigned d, input bit rx,
                       input bit cm, input bit ri, input bit op, input bit hr, input bit ir);
      exp_t e;
      reset = rst; mem_ready = mr; data_in = d[7:0]; reset_xpt = rx; set_cm1 = cm;
      reset_itable = ri; ophd = op; halt_req = hr; int_req = ir;
      model_edge(rst, mr, d & 'hFF, rx, cm, ri, op, hr, ir);
      e.xpt = m_phase; e.itable = m_opcode; e.prefix = m_prefix; e.iy = m_iy; e.perr = m_perr;
      e.m1 = (m_mode == MODE_FETCH); e.en = (m_mode == MODE_EXEC); e.halted = (m_mode == MODE_HALT);
      sb.push_back(e);
      @(negedge clock);
   endtask

   task automatic idle(input bit mr);
      step(0, mr, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fetch_byte(input int unsigned b);
      step(0, 1, b, 0, 0, 0, 0, 0, 0);
      step(0, 1, b, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("XPT",            XPT,            e.xpt);
            check("notXPT",         notXPT,         ~e.xpt & 'hF);
            check("ITABLE",         ITABLE,         e.itable);
            check("notITABLE",      notITABLE,      ~e.itable & 'hFF);
            check("prefix",         prefix,         e.prefix);
            check("prefix_iy",      prefix_iy,      e.iy);
            check("phase_error",    phase_error,    e.perr);
            check("m1",             m1,             e.m1);
            check("decoder_enable", decoder_enable, e.en);
            check("halted",         halted,         e.halted);
         end
      end
   end

   logic [7:0] pfx_bytes [4] = '{8'hCB, 8'hDD, 8'hED, 8'hFD};

   initial begin : stimulus
      bit          rx, cm, hr, rst;
      int unsigned d;
      reset = 1'b1; mem_ready = 0; data_in = 0; reset_xpt = 0; set_cm1 = 0;
      reset_itable = 0; ophd = 0; halt_req = 0; int_req = 0;
      @(negedge clock);

      // Opcode fetch after reset
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_m1", m1, 1); check("rst_en", decoder_enable, 0); check("rst_xpt", XPT, 0);
      fetch_byte('h3E);
      check("t1_itable", ITABLE, 'h3E); check("t1_notitable", notITABLE, 'hC1);
      check("t1_xpt", XPT, 2); check("t1_en", decoder_enable, 1); check("t1_m1", m1, 0);

      // Wait states hold XPT; reset_xpt overrides mem_ready=0
      idle(1); idle(1);
      idle(0); idle(0); idle(0);
      check("t2_hold", XPT, 4);
      step(0, 0, 0, 1, 1, 0, 0, 0, 0);
      check("t2_xpt", XPT, 0); check("t2_m1", m1, 1);

      // DD prefix then opcode, cleared by ophd
      fetch_byte('hDD); fetch_byte('h21);
      check("t3_prefix", prefix, 2); check("t3_iy", prefix_iy, 0); check("t3_itable", ITABLE, 'h21);
      step(0, 1, 0, 1, 1, 0, 1, 0, 0);
      check("t3_clear", prefix, 0); check("t3_m1", m1, 1);

      // Prefix chain, last one wins
      fetch_byte('hFD); fetch_byte('hDD); fetch_byte('hED); fetch_byte('h46);
      check("t4_prefix", prefix, 3); check("t4_itable", ITABLE, 'h46);

      // Counter saturation and sticky overflow
      for (int i = 0; i < 13; i++) idle(1);
      check("t5_xpt15", XPT, 15); check("t5_noerr", phase_error, 0);
      idle(1);
      check("t5_err", phase_error, 1); check("t5_sat", XPT, 15);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check("t5_rst", phase_error, 0);

      // HALT entry/exit, then reset during a wait state
      fetch_byte('h76);
      step(0, 1, 0, 1, 0, 1, 0, 1, 0);
      check("t6_halted", halted, 1); check("t6_xpt", XPT, 0); check("t6_en", decoder_enable, 0);
      step(0, 1, 0, 1, 1, 0, 1, 0, 0);
      check("t6_stay", halted, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t6_m1", m1, 1); check("t6_exit", halted, 0);
      idle(1);
      check("t6_xpt1", XPT, 1);
      step(1, 0, 'hCB, 0, 0, 0, 0, 0, 0);
      check("t6_rst_xpt", XPT, 0); check("t6_rst_itable", ITABLE, 0); check("t6_rst_m1", m1, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         d   = ($urandom_range(0, 2) == 0) ? pfx_bytes[$urandom_range(0, 3)] : $urandom_range(0, 255);
         rx  = (m_mode == MODE_EXEC) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
         cm  = $urandom_range(0, 1);
         hr  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step(rst, ($urandom_range(0, 3) != 0), d, rx, cm, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), hr, ($urandom_range(0, 4) == 0));
      end

      idle(0);
      @(negedge clock);
      check("scoreboard_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
